ubutterfly_s2b_capture: RTL and testbench
=========================================

// Module: ubutterfly_s2b_capture
// PURPOSE
//  Downstream stage of the unary butterfly. Counts the 1s on the four butterfly output
//  bitstreams (Real0/Img0/Real1/Img1) over a fixed window of 2^BITWIDTH enabled cycles.
//  Presents the four binary results with a valid/ready handshake, to the next FFT stage
//  or to the result readout.
//  Discards SKIP leading cycles so butterfly pipeline fill is not counted.
// PARAMETERS
//  BITWIDTH  8  result width; window length = 2^BITWIDTH enabled cycles
//  SKIP      2  enabled cycles discarded after start, before counting begins (0 allowed)
// PORTS
//  iClk     in   1         clock, all state on rising edge
//  iRst     in   1         asynchronous, active-high reset
//  iEn      in   1         cycle enable; low freezes counters/FSM (handshake still served)
//  iClr     in   1         synchronous abort: return to IDLE, clear counters, drop oValid
//  iStart   in   1         begin a capture window (sampled in IDLE only)
//  iReal0   in   1         butterfly output bitstream
//  iImg0    in   1         butterfly output bitstream
//  iReal1   in   1         butterfly output bitstream
//  iImg1    in   1         butterfly output bitstream
//  oReal0   out  BITWIDTH  captured count, Real0 stream
//  oImg0    out  BITWIDTH  captured count, Img0 stream
//  oReal1   out  BITWIDTH  captured count, Real1 stream
//  oImg1    out  BITWIDTH  captured count, Img1 stream
//  oValid   out  1         results valid; held until accepted
//  iReady   in   1         consumer accepts when oValid && iReady
//  oBusy    out  1         high in SKIP or RUN
// BEHAVIOUR
//  Reset: FSM=IDLE, all counters 0, all o* outputs 0, oValid=0, oBusy=0.
//  FSM states: IDLE -> SKIP -> RUN -> HOLD -> IDLE.
//   IDLE: on iStart && iEn, go to SKIP, or to RUN when SKIP==0; counters cleared.
//   SKIP: count SKIP enabled cycles, inputs ignored, then go to RUN.
//   RUN: each enabled cycle, add each input bit to its channel counter (BITWIDTH+1 bits).
//        After exactly 2^BITWIDTH enabled cycles, register results and go to HOLD.
//   HOLD: oValid=1, outputs stable. On iReady go to IDLE and drop oValid the next cycle;
//         outputs keep their last value.
//  Result = min(count, 2^BITWIDTH-1): an all-ones window saturates to all ones.
//  Latency: iStart to oValid = SKIP + 2^BITWIDTH + 1 enabled cycles.
//  iStart outside IDLE is ignored. No queuing: a new window needs HOLD to complete.
//  iEn low: SKIP/RUN counters and the window counter hold. iReady in HOLD is still
//   honoured regardless of iEn.
//  iClr has priority over iStart and iReady. Any state -> IDLE, oValid=0, outputs cleared to 0.
//  iRst mid-window: immediate return to reset values; no partial result is emitted.
//  Window counter wraps exactly once per window; no count is lost at the RUN->HOLD edge.
//   The last RUN cycle's bit is included.
// CONFIGURATION
//  `BIPOLAR_SIGNED_EN defined: outputs are two's complement bipolar values.
//   Result = count - 2^(BITWIDTH-1), saturated to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
//   Implemented as the MSB-inverted saturated count.
//  Not defined: outputs are unsigned saturated counts, as described above.
// TESTING (BITWIDTH=4, SKIP=2, unsigned unless noted)
//  1. iReal0=1 constant, others 0, iStart pulse -> oValid after 19 cycles;
//     oReal0=15 (saturated), others 0.
//  2. iImg0 alternating 1,0 from cycle 0 -> oImg0=8;
//     pattern with 5 ones in the 16 RUN cycles on iImg1 -> oImg1=5.
//  3. iReady low 6 cycles after oValid, iStart pulsed during HOLD -> oValid and outputs
//     stable, start ignored; iReady=1 -> oValid=0 next cycle, FSM IDLE.
//  4. iEn toggled 50% during RUN with test-1 stimulus -> oValid at ~2x latency,
//     oReal0=15; iClr pulsed mid-RUN -> IDLE, outputs 0, no oValid.
//  5. iRst asserted mid-RUN (async, between edges) -> all outputs 0, oValid=0, oBusy=0
//     immediately; fresh iStart gives correct result.
//  6. `BIPOLAR_SIGNED_EN: all-ones -> 4'h7, all-zeros -> 4'h8 (-8), alternating -> 4'h0.

Source files
------------

// File: rtl/ubutterfly_s2b_capture.sv
// ubutterfly_s2b_capture: counts ones on four butterfly bitstreams over 2^BITWIDTH enabled cycles; optional `BIPOLAR_SIGNED_EN gives two's complement bipolar results
module ubutterfly_s2b_capture #(
    parameter int BITWIDTH = 8,
    parameter int SKIP     = 2
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iStart,
    input  logic                iReal0,
    input  logic                iImg0,
    input  logic                iReal1,
    input  logic                iImg1,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oReal0,
    output logic [BITWIDTH-1:0] oImg0,
    output logic [BITWIDTH-1:0] oReal1,
    output logic [BITWIDTH-1:0] oImg1,
    output logic                oValid,
    output logic                oBusy
);
    localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [BITWIDTH-1:0] MSB = 1 << (BITWIDTH - 1);

    typedef enum logic [1:0] {sIdle, sSkip, sRun, sHold} stateT;

    stateT               state;
    logic [SW-1:0]       skipCnt;
    logic [BITWIDTH-1:0] winCnt;
    logic [BITWIDTH:0]   cnt    [4];
    logic [BITWIDTH:0]   nxtCnt [4];
    logic [BITWIDTH-1:0] satVal [4];
    logic [BITWIDTH-1:0] resVal [4];
    logic [BITWIDTH-1:0] res    [4];
    logic [3:0]          bits;

    assign bits   = {iImg1, iReal1, iImg0, iReal0};
    assign oReal0 = res[0];
    assign oImg0  = res[1];
    assign oReal1 = res[2];
    assign oImg1  = res[3];

    // Next count includes the current bit so the final RUN cycle is counted; saturate, then optionally flip MSB for bipolar
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nxtCnt[k] = cnt[k] + {{BITWIDTH{1'b0}}, bits[k]};
            satVal[k] = nxtCnt[k][BITWIDTH] ? '1 : nxtCnt[k][BITWIDTH-1:0];
`ifdef BIPOLAR_SIGNED_EN
            resVal[k] = satVal[k] ^ MSB;
`else
            resVal[k] = satVal[k];
`endif
        end
    end

    // Capture FSM: IDLE -> SKIP -> RUN -> HOLD -> IDLE, with registered results and status
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= sIdle;
            skipCnt <= '0;
            winCnt  <= '0;
            cnt     <= '{default: '0};
            res     <= '{default: '0};
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
        end else if (iClr) begin
            state   <= sIdle;
            skipCnt <= '0;
            winCnt  <= '0;
            cnt     <= '{default: '0};
            res     <= '{default: '0};
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            case (state)
                sIdle: if (iStart && iEn) begin
                    state   <= (SKIP == 0) ? sRun : sSkip;
                    skipCnt <= '0;
                    winCnt  <= '0;
                    cnt     <= '{default: '0};
                    oBusy   <= 1'b1;
                end
                sSkip: if (iEn) begin
                    skipCnt <= skipCnt + SW'(1);
                    if (int'(skipCnt) == SKIP - 1) state <= sRun;
                end
                sRun: if (iEn) begin
                    cnt    <= nxtCnt;
                    winCnt <= winCnt + BITWIDTH'(1);
                    if (&winCnt) begin
                        state  <= sHold;
                        res    <= resVal;
                        oValid <= 1'b1;
                        oBusy  <= 1'b0;
                    end
                end
                sHold: if (iReady) begin
                    state  <= sIdle;
                    oValid <= 1'b0;
                end
                default: state <= sIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ubutterfly_s2b_capture.sv
// tb_ubutterfly_s2b_capture: directed vector bench for the bitstream capture stage (BITWIDTH=4, SKIP=2)
module tb_ubutterfly_s2b_capture;
    localparam int BW = 4;

    logic iClk = 1'b0, iRst = 1'b1, iEn = 1'b0, iClr = 1'b0, iStart = 1'b0, iReady = 1'b0;
    logic iReal0 = 1'b0, iImg0 = 1'b0, iReal1 = 1'b0, iImg1 = 1'b0;
    logic [BW-1:0] oReal0, oImg0, oReal1, oImg1;
    logic oValid, oBusy;
    logic [3:0][BW-1:0] oAll;
    int checks = 0, failures = 0;

    typedef struct packed {
        logic [3:0][15:0] p;
        logic [3:0][3:0]  e;
    } vecT;

    vecT vecs [4];

    ubutterfly_s2b_capture #(.BITWIDTH(BW), .SKIP(2)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iStart(iStart),
        .iReal0(iReal0), .iImg0(iImg0), .iReal1(iReal1), .iImg1(iImg1),
        .iReady(iReady), .oReal0(oReal0), .oImg0(oImg0), .oReal1(oReal1),
        .oImg1(oImg1), .oValid(oValid), .oBusy(oBusy)
    );

    assign oAll = {oImg1, oReal1, oImg0, oReal0};

    always #5 iClk = ~iClk;

    function automatic logic [3:0] fx(input logic [3:0] v);
`ifdef BIPOLAR_SIGNED_EN
        return v ^ 4'h8;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Start pulse, 3 junk-ones edges (start + 2 skip), then 16 RUN edges from the patterns
    task automatic runWindow(input logic [3:0][15:0] p, input string tag);
        int lat = 0;
        iStart = 1'b1;
        iEn = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (n >= 4 && n <= 19)
                {iImg1, iReal1, iImg0, iReal0} = {p[3][n-4], p[2][n-4], p[1][n-4], p[0][n-4]};
            else
                {iImg1, iReal1, iImg0, iReal0} = 4'hF;
            step();
            iStart = 1'b0;
            if (n == 10) chk({tag, " busy"}, int'(oBusy), 1);
            if (oValid) begin
                lat = n;
                break;
            end
        end
        {iImg1, iReal1, iImg0, iReal0} = 4'h0;
        chk({tag, " latency"}, lat, 19);
    endtask

    task automatic accept(input string tag, input logic [3:0] keep);
        iReady = 1'b1;
        step();
        iReady = 1'b0;
        chk({tag, " valid drop"}, int'(oValid), 0);
        chk({tag, " keep"}, int'(oReal0), int'(keep));
    endtask

    initial begin
        vecs[0].p = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[0].e = {fx(4'd0), fx(4'd0), fx(4'd0), fx(4'd15)};
        vecs[1].p = {16'h001F, 16'h0001, 16'hAAAA, 16'h0000};
        vecs[1].e = {fx(4'd5), fx(4'd1), fx(4'd8), fx(4'd0)};
        vecs[2].p = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2].e = {fx(4'd0), fx(4'd0), fx(4'd0), fx(4'd0)};
        vecs[3].p = {16'h7FFF, 16'h0001, 16'h8000, 16'hFFFE};
        vecs[3].e = {fx(4'd15), fx(4'd1), fx(4'd1), fx(4'd15)};

        repeat (3) step();
        chk("reset valid", int'(oValid), 0);
        chk("reset busy", int'(oBusy), 0);
        chk("reset outs", int'(oAll), 0);
        iRst = 1'b0;
        step();
        chk("idle outs", int'(oAll), 0);

        for (int v = 0; v < 4; v++) begin
            runWindow(vecs[v].p, $sformatf("vec%0d", v));
            for (int c = 0; c < 4; c++)
                chk($sformatf("vec%0d ch%0d", v, c), int'(oAll[c]), int'(vecs[v].e[c]));
            accept($sformatf("vec%0d", v), vecs[v].e[0]);
        end

        runWindow(vecs[0].p, "hold");
        for (int i = 0; i < 6; i++) begin
            iStart = (i == 2);
            step();
            chk($sformatf("hold valid %0d", i), int'(oValid), 1);
            chk($sformatf("hold out %0d", i), int'(oReal0), int'(fx(4'd15)));
        end
        iStart = 1'b0;
        accept("hold", fx(4'd15));
        step();
        chk("hold idle busy", int'(oBusy), 0);
        chk("hold idle valid", int'(oValid), 0);

        begin
            int lat = 0;
            iStart = 1'b1;
            iEn = 1'b1;
            iReal0 = 1'b1;
            for (int n = 1; n <= 100; n++) begin
                iEn = (n == 1) ? 1'b1 : n[0];
                step();
                iStart = 1'b0;
                if (oValid) begin
                    lat = n;
                    break;
                end
            end
            iEn = 1'b1;
            iReal0 = 1'b0;
            chk("en toggle latency", lat, 37);
            chk("en toggle real0", int'(oReal0), int'(fx(4'd15)));
            accept("en toggle", fx(4'd15));
        end

        iStart = 1'b1;
        iReal0 = 1'b1;
        step();
        iStart = 1'b0;
        repeat (9) step();
        iClr = 1'b1;
        step();
        iClr = 1'b0;
        chk("clr valid", int'(oValid), 0);
        chk("clr busy", int'(oBusy), 0);
        chk("clr outs", int'(oAll), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (oValid) seen++;
            end
            chk("clr no valid", seen, 0);
        end
        iReal0 = 1'b0;

        runWindow(vecs[0].p, "pre rst");
        accept("pre rst", fx(4'd15));
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        repeat (8) step();
        chk("mid run busy", int'(oBusy), 1);
        #2 iRst = 1'b1;
        #1;
        chk("async rst outs", int'(oAll), 0);
        chk("async rst valid", int'(oValid), 0);
        chk("async rst busy", int'(oBusy), 0);
        #2 iRst = 1'b0;
        step();
        runWindow(vecs[1].p, "post rst");
        for (int c = 0; c < 4; c++)
            chk($sformatf("post rst ch%0d", c), int'(oAll[c]), int'(vecs[1].e[c]));
        accept("post rst", vecs[1].e[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
